// File: rtl/conv3x3_window_mac_if.sv
// Bundle between the 3x3 line-buffer taps / coefficient source and the window MAC.
//   en, clear       : pixel strobe and synchronous frame restart
//   tap1..tap9      : unsigned window taps, tap1 oldest (r-2,c-2), tap9 newest (r,c)
//   weights, bias   : 9 packed signed 8-bit weights, signed 16-bit bias
//   out_*           : valid-qualified result stream, frame_done on the last pixel
// master drives the pixel side, slave is the MAC.
interface conv3x3_window_mac_if;
  logic        en;
  logic        clear;
  logic [7:0]  tap1, tap2, tap3, tap4, tap5, tap6, tap7, tap8, tap9;
  logic [71:0] weights;
  logic [15:0] bias;
  logic [7:0]  out_data;
  logic        out_valid;
  logic [3:0]  out_row;
  logic [3:0]  out_col;
  logic        frame_done;

  modport master (
    output en, clear, tap1, tap2, tap3, tap4, tap5, tap6, tap7, tap8, tap9, weights, bias,
    input  out_data, out_valid, out_row, out_col, frame_done
  );

  modport slave (
    input  en, clear, tap1, tap2, tap3, tap4, tap5, tap6, tap7, tap8, tap9, weights, bias,
    output out_data, out_valid, out_row, out_col, frame_done
  );
endinterface

// File: rtl/conv3x3_window_mac.sv
// 3x3 window MAC behind a line buffer: tracks the raster position of every strobed pixel,
// suppresses windows that straddle a row/frame edge, and produces sum + bias, ReLU,
// arithmetic shift and 8-bit saturation for every valid window, 3 clocks after its strobe.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : slave side of conv3x3_window_mac_if (strobe, taps, coefficients, result stream)
module conv3x3_window_mac #(
  parameter int unsigned FEATURE_MAP_SIZE = 14,
  parameter int unsigned KERNEL_SIZE      = 3,
  parameter int unsigned SHIFT            = 7,
  parameter int unsigned ACC_W            = 22
) (
  input logic                  clk,
  input logic                  rst,
  conv3x3_window_mac_if.slave  bus
);

  localparam int unsigned Edge    = KERNEL_SIZE - 1;
  localparam int unsigned OutLast = FEATURE_MAP_SIZE - KERNEL_SIZE;

  logic [7:0]              tap [9];
  logic [3:0]              row_q, col_q;
  logic                    last_col, last_row, win_ok;
  logic                    v0_q, v1_q, v2_q;
  logic [3:0]              r0_q, c0_q, r1_q, c1_q, r2_q, c2_q;
  logic signed [16:0]      prod_d [9];
  logic signed [16:0]      prod_q [9];
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic [ACC_W-1:0]        y_d;
  logic [7:0]              data_d;
  logic                    fd_d;
  logic [7:0]              out_data_q;
  logic                    out_valid_q, frame_done_q;
  logic [3:0]              out_row_q, out_col_q;

  assign tap[0] = bus.tap1;
  assign tap[1] = bus.tap2;
  assign tap[2] = bus.tap3;
  assign tap[3] = bus.tap4;
  assign tap[4] = bus.tap5;
  assign tap[5] = bus.tap6;
  assign tap[6] = bus.tap7;
  assign tap[7] = bus.tap8;
  assign tap[8] = bus.tap9;

  assign last_col = (col_q == 4'(FEATURE_MAP_SIZE - 1));
  assign last_row = (row_q == 4'(FEATURE_MAP_SIZE - 1));
  // Decided on the pre-increment position; columns 0/1 would mix in the previous row.
  assign win_ok   = bus.en && (row_q >= 4'(Edge)) && (col_q >= 4'(Edge));

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({1'b0, tap[k]}) * $signed(bus.weights[8*k +: 8]);
    end
  end

  always_comb begin
    acc_d = {{(ACC_W-16){bus.bias[15]}}, bus.bias};
    for (int k = 0; k < 9; k++) begin
      acc_d = acc_d + {{(ACC_W-17){prod_q[k][16]}}, prod_q[k]};
    end
  end

  // Shift is only used when acc is non-negative, so its sign fill never matters.
  always_comb begin
    y_d    = acc_q >>> SHIFT;
    data_d = acc_q[ACC_W-1] ? 8'd0 : ((|y_d[ACC_W-1:8]) ? 8'hff : y_d[7:0]);
    fd_d   = (r2_q == 4'(OutLast)) && (c2_q == 4'(OutLast));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else if (bus.clear) begin
      row_q <= '0;
      col_q <= '0;
    end else if (bus.en) begin
      if (last_col) begin
        col_q <= '0;
        row_q <= last_row ? 4'd0 : row_q + 4'd1;
      end else begin
        col_q <= col_q + 4'd1;
      end
    end
  end

  // Valid bits follow each stage; payload registers only load behind a valid bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q         <= 1'b0;
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      {r0_q, c0_q, r1_q, c1_q, r2_q, c2_q} <= '0;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      acc_q        <= '0;
      out_data_q   <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
    end else begin
      v0_q         <= win_ok && !bus.clear;
      v1_q         <= v0_q && !bus.clear;
      v2_q         <= v1_q && !bus.clear;
      out_valid_q  <= v2_q && !bus.clear;
      frame_done_q <= v2_q && !bus.clear && fd_d;
      if (win_ok) begin
        r0_q <= row_q - 4'(Edge);
        c0_q <= col_q - 4'(Edge);
      end
      if (v0_q) begin
        for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
        r1_q <= r0_q;
        c1_q <= c0_q;
      end
      if (v1_q) begin
        acc_q <= acc_d;
        r2_q  <= r1_q;
        c2_q  <= c1_q;
      end
      if (v2_q && !bus.clear) begin
        out_data_q <= data_d;
        out_row_q  <= r2_q;
        out_col_q  <= c2_q;
      end
    end
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_conv3x3_window_mac.sv
// Bench for conv3x3_window_mac: two instances (SHIFT=0 and SHIFT=7) share one stimulus.
// A behavioural line buffer feeds the taps from a whole-image array; expected pulses are
// computed directly from the image with integer arithmetic and compared against the
// recorded output stream (cycle, data, position, frame_done).
module tb_conv3x3_window_mac;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  d0;
    logic [7:0]  d7;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        fd;
    logic        same;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv3x3_window_mac_if bus0 ();
  conv3x3_window_mac_if bus7 ();

  assign bus7.en      = bus0.en;
  assign bus7.clear   = bus0.clear;
  assign bus7.tap1    = bus0.tap1;
  assign bus7.tap2    = bus0.tap2;
  assign bus7.tap3    = bus0.tap3;
  assign bus7.tap4    = bus0.tap4;
  assign bus7.tap5    = bus0.tap5;
  assign bus7.tap6    = bus0.tap6;
  assign bus7.tap7    = bus0.tap7;
  assign bus7.tap8    = bus0.tap8;
  assign bus7.tap9    = bus0.tap9;
  assign bus7.weights = bus0.weights;
  assign bus7.bias    = bus0.bias;

  conv3x3_window_mac #(.SHIFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  conv3x3_window_mac #(.SHIFT(7)) dut7 (.clk(clk), .rst(rst), .bus(bus7));

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] img [14][14];
  logic [7:0] pend_taps [9];
  bit   pend;
  int   wts [9];
  int   bias_v;
  int   fill;
  int   mr, mc;
  int   last_edge;
  rec_t exp_q [$];
  rec_t obs_q [$];
  int   n_pass = 0;
  int   n_total = 0;

  // Output recorder: samples both instances on the falling edge.
  initial forever begin
    rec_t r;
    @(negedge clk);
    if (bus0.out_valid || bus7.out_valid) begin
      r.cyc  = cyc;
      r.d0   = bus0.out_data;
      r.d7   = bus7.out_data;
      r.row  = bus0.out_row;
      r.col  = bus0.out_col;
      r.fd   = bus0.frame_done;
      r.same = bus0.out_valid && bus7.out_valid && (bus7.out_row == bus0.out_row) &&
               (bus7.out_col == bus0.out_col) && (bus7.frame_done == bus0.frame_done);
      obs_q.push_back(r);
    end
  end

  function automatic logic [7:0] quant(input int acc, input int s);
    if (acc < 0) return 8'd0;
    if ((acc >>> s) > 255) return 8'hff;
    return 8'(acc >>> s);
  endfunction

  function automatic rec_t model(input int r, input int c, input int emit);
    rec_t e;
    int acc = bias_v;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += int'(img[r-2+i][c-2+j]) * wts[3*i+j];
    e.cyc  = 32'(emit);
    e.d0   = quant(acc, 0);
    e.d7   = quant(acc, 7);
    e.row  = 4'(r - 2);
    e.col  = 4'(c - 2);
    e.fd   = (r == 13) && (c == 13);
    e.same = 1'b1;
    return e;
  endfunction

  task automatic regen();
    for (int r = 0; r < 14; r++)
      for (int c = 0; c < 14; c++)
        img[r][c] = (fill < 0) ? 8'($urandom) : 8'(fill);
  endtask

  // Drop expected pulses that would appear at or after the given edge.
  task automatic flush(input int edge_n);
    rec_t keep [$];
    foreach (exp_q[i]) if (int'(exp_q[i].cyc) < edge_n) keep.push_back(exp_q[i]);
    exp_q = keep;
  endtask

  task automatic set_params(input int f, input int w, input bit rnd_w, input int b);
    @(negedge clk);
    fill = f;
    for (int k = 0; k < 9; k++) begin
      wts[k] = rnd_w ? int'($urandom_range(0, 255)) - 128 : w;
      bus0.weights[8*k +: 8] = 8'(wts[k]);
    end
    bias_v = b;
    bus0.bias = 16'(b);
    regen();
  endtask

  // One clock of stimulus; taps for the previously strobed pixel appear after its edge.
  task automatic drive(input bit e, input bit c);
    @(negedge clk);
    if (pend) begin
      bus0.tap1 = pend_taps[0]; bus0.tap2 = pend_taps[1]; bus0.tap3 = pend_taps[2];
      bus0.tap4 = pend_taps[3]; bus0.tap5 = pend_taps[4]; bus0.tap6 = pend_taps[5];
      bus0.tap7 = pend_taps[6]; bus0.tap8 = pend_taps[7]; bus0.tap9 = pend_taps[8];
      pend = 0;
    end
    bus0.en    = e;
    bus0.clear = c;
    if (c) begin
      flush(cyc + 1);
      mr = 0;
      mc = 0;
    end else if (e) begin
      if (mr == 0 && mc == 0 && fill < 0) regen();
      last_edge = cyc + 1;
      if (mr >= 2 && mc >= 2) exp_q.push_back(model(mr, mc, last_edge + 3));
      for (int k = 0; k < 9; k++)
        pend_taps[k] = (mr >= 2 && mc >= 2) ? img[mr-2+k/3][mc-2+k%3] : 8'($urandom);
      pend = 1;
      mc++;
      if (mc == 14) begin
        mc = 0;
        mr = (mr + 1) % 14;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus0.en   = 1'($urandom);
      bus0.tap5 = 8'($urandom);
      bus0.tap9 = 8'($urandom);
      @(negedge clk);
      n_total++;
      if ({bus0.out_valid, bus0.frame_done, bus0.out_data, bus0.out_row, bus0.out_col,
           bus7.out_valid, bus7.frame_done, bus7.out_data, bus7.out_row, bus7.out_col} !== '0)
        $display("FAIL reset_outputs cycle %0d: got valid=%b fd=%b data=%h row=%0d col=%0d want all 0",
                 i, bus0.out_valid, bus0.frame_done, bus0.out_data, bus0.out_row, bus0.out_col);
      else n_pass++;
    end
    @(negedge clk);
    bus0.en = 1'b0;
    rst = 1'b0;
    mr = 0;
    mc = 0;
    pend = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_ones();
    int t0, nfd;
    set_params(1, 1, 0, 0);
    drive(0, 1);
    drive(1, 0);
    t0 = last_edge;
    repeat (2 * 196 - 1) drive(1, 0);
    idle(6);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL ones_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL ones_pulse %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    n_total++;
    if (obs_q.size() == 0 ||
        {obs_q[0].cyc, obs_q[0].d0, obs_q[0].row, obs_q[0].col} !== {32'(t0 + 33), 8'd9, 8'd0})
      $display("FAIL ones_first_pulse: got %h want cyc=%0d data=9 at (0,0)",
               obs_q.size() ? obs_q[0] : '0, t0 + 33);
    else n_pass++;
    nfd = 0;
    foreach (obs_q[i]) nfd += obs_q[i].fd;
    n_total++;
    if (nfd !== 2) $display("FAIL ones_frame_done: got %0d want 2", nfd);
    else n_pass++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_fixed(input string name, input int f, input int w, input int b);
    set_params(f, w, 0, b);
    drive(0, 1);
    repeat (196) drive(1, 0);
    idle(6);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL %s_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL %s_pulse %0d: got %h want %h", name, i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_sparse_en();
    int nfd;
    set_params(1, 1, 0, 0);
    drive(0, 1);
    repeat (196) begin
      drive(1, 0);
      idle(2);
    end
    idle(6);
    n_total++;
    if (obs_q.size() !== 144) $display("FAIL sparse_count: got %0d want 144", obs_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL sparse_pulse %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    nfd = 0;
    foreach (obs_q[i]) if (obs_q[i].fd) nfd += (obs_q[i].row == 11 && obs_q[i].col == 11) ? 1 : 100;
    n_total++;
    if (nfd !== 1) $display("FAIL sparse_frame_done: got %0d want 1", nfd);
    else n_pass++;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_abort(input bit use_rst);
    set_params(-1, 0, 1, int'($urandom_range(0, 65535)) - 32768);
    drive(0, 1);
    repeat (50) drive(1, 0);
    if (use_rst) begin
      @(negedge clk);
      #1;
      rst = 1'b1;
      flush(cyc + 1);
      mr = 0;
      mc = 0;
      pend = 0;
      bus0.en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
    end else begin
      drive(1, 1);
    end
    repeat (196) drive(1, 0);
    idle(6);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL abort%0d_count: got %0d want %0d", use_rst, obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL abort%0d_pulse %0d: got %h want %h", use_rst, i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_random();
    set_params(-1, 0, 1, int'($urandom_range(0, 65535)) - 32768);
    drive(0, 1);
    repeat (600) drive(($urandom_range(0, 2) != 0), 0);
    idle(6);
    n_total++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL random_count: got %0d want %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_total++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL random_pulse %0d: got %h want %h", i, obs_q[i], exp_q[i]);
      else n_pass++;
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus0.en = 1'b0;
    bus0.clear = 1'b0;
    bus0.tap1 = '0; bus0.tap2 = '0; bus0.tap3 = '0; bus0.tap4 = '0; bus0.tap5 = '0;
    bus0.tap6 = '0; bus0.tap7 = '0; bus0.tap8 = '0; bus0.tap9 = '0;
    bus0.weights = '0;
    bus0.bias = '0;
    fill = 0;
    pend = 0;
    test_reset();
    test_ones();
    test_fixed("relu", 200, -1, 0);
    test_fixed("saturate", 255, 127, 32767);
    test_sparse_en();
    test_abort(1);
    test_abort(0);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
